// File: rtl/rx_block_sync.sv
// 64b/66b receive block synchroniser: watches sync headers from the gearbox,
// requests bit slips until alignment is found and reports block_lock.
module rx_block_sync #(
    parameter int SH_CNT_N    = 64,
    parameter int INVLD_MAX   = 16,
    parameter int SLIP_WAIT_N = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_i,
    input  logic [1:0] head_i,
    output logic       slip_o,
    output logic       lock_o
);

    localparam int SH_W   = $clog2(SH_CNT_N + 1);
    localparam int INV_W  = $clog2(INVLD_MAX + 1);
    localparam int WAIT_W = (SLIP_WAIT_N > 1) ? $clog2(SLIP_WAIT_N) : 1;

    typedef enum logic {
        ST_TEST,
        ST_SLIP_WAIT
    } state_t;

    state_t              r_state;
    logic [SH_W-1:0]     r_shCnt;
    logic [INV_W-1:0]    r_invldCnt;
    logic [WAIT_W-1:0]   r_waitCnt;
    logic                r_lock;
    logic                r_slip;

    state_t              w_stateNext;
    logic [SH_W-1:0]     w_shNext;
    logic [INV_W-1:0]    w_invldNext;
    logic [WAIT_W-1:0]   w_waitNext;
    logic                w_lockNext;
    logic                w_slipNext;

    logic                w_accept;
    logic                w_headBad;
    logic [SH_W-1:0]     w_shInc;
    logic [INV_W-1:0]    w_invldInc;
    logic                w_doSlip;
    logic                w_windowEnd;

    // Stored counts never exceed terminal-1, so the increments cannot overflow.
    assign w_headBad   = (head_i == 2'b00) || (head_i == 2'b11);
    assign w_accept    = valid_i && (r_state == ST_TEST);
    assign w_shInc     = r_shCnt + SH_W'(1);
    assign w_invldInc  = r_invldCnt + INV_W'(w_headBad);
    assign w_doSlip    = (w_headBad && !r_lock) ||
                         (r_lock && (w_invldInc == INV_W'(INVLD_MAX)));
    assign w_windowEnd = (w_shInc == SH_W'(SH_CNT_N));

    always_comb begin
        w_stateNext = r_state;
        w_shNext    = r_shCnt;
        w_invldNext = r_invldCnt;
        w_waitNext  = r_waitCnt;
        w_lockNext  = r_lock;
        w_slipNext  = 1'b0;

        case (r_state)
            ST_TEST: begin
                if (w_accept) begin
                    // Slip outranks the end-of-window decision on the same header.
                    if (w_doSlip) begin
                        w_slipNext  = 1'b1;
                        w_lockNext  = 1'b0;
                        w_shNext    = '0;
                        w_invldNext = '0;
                        w_waitNext  = '0;
                        w_stateNext = ST_SLIP_WAIT;
                    end else if (w_windowEnd) begin
                        if (w_invldInc == '0) begin
                            w_lockNext = 1'b1;
                        end
                        w_shNext    = '0;
                        w_invldNext = '0;
                    end else begin
                        w_shNext    = w_shInc;
                        w_invldNext = w_invldInc;
                    end
                end
            end
            ST_SLIP_WAIT: begin
                w_lockNext = 1'b0;
                if (r_waitCnt == WAIT_W'(SLIP_WAIT_N - 1)) begin
                    w_waitNext  = '0;
                    w_stateNext = ST_TEST;
                end else begin
                    w_waitNext = r_waitCnt + WAIT_W'(1);
                end
            end
            default: begin
                w_stateNext = ST_TEST;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_TEST;
            r_shCnt    <= '0;
            r_invldCnt <= '0;
            r_waitCnt  <= '0;
            r_lock     <= 1'b0;
            r_slip     <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_shCnt    <= w_shNext;
            r_invldCnt <= w_invldNext;
            r_waitCnt  <= w_waitNext;
            r_lock     <= w_lockNext;
            r_slip     <= w_slipNext;
        end
    end

    assign slip_o = r_slip;
    assign lock_o = r_lock;

endmodule

// File: doc/rx_block_sync.md
RX_BLOCK_SYNC -- requirements
Module: rx_block_sync

Interface
REQ-001 SHALL have parameter SH_CNT_N, default 64, meaning the sync headers per test window.
REQ-002 SHALL have parameter INVLD_MAX, default 16, meaning the invalid headers per window that force a slip.
REQ-003 SHALL have parameter SLIP_WAIT_N, default 3, meaning the cycles after a slip pulse during which input is ignored.
REQ-004 SHALL have port clk, input, 1 bit: RX parallel clock from transceiver rx_clkout; the block has one clock.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port valid_i, input, 1 bit: the gearbox presents a 66-bit block this cycle.
REQ-007 SHALL have port head_i, input, 2 bits: sync header of the presented block.
REQ-008 SHALL have port slip_o, output, 1 bit: one-cycle request to the gearbox to shift its alignment by one bit.
REQ-009 SHALL have port lock_o, output, 1 bit: block_lock, consumed by the descrambler/decoder and the reset controller.

Function
REQ-010 SHALL treat a header as valid when head_i is 2'b01 or 2'b10, and as invalid when it is 2'b00 or 2'b11.
REQ-011 SHALL accept a header only on a cycle where valid_i=1 and the block is not in slip-wait; all other cycles leave the counters unchanged.
REQ-012 SHALL keep sh_cnt (0..SH_CNT_N, 7 bits at default) and invld_cnt (0..INVLD_MAX, 5 bits at default); each accepted header adds 1 to sh_cnt, and adds 1 to invld_cnt when the header is invalid.
REQ-013 SHALL use three states: TEST (counting), SLIP_WAIT (ignoring input), and GOOD (encoded by lock_o=1 in TEST).
REQ-014 SHALL evaluate every transition on the post-increment counter values of the accepted header.
REQ-015 SHALL, when unlocked and an invalid header is accepted, pulse slip_o, clear both counters and enter SLIP_WAIT.
REQ-016 SHALL, when locked and invld_cnt reaches INVLD_MAX, clear lock_o, pulse slip_o, clear both counters and enter SLIP_WAIT.
REQ-017 SHALL, when sh_cnt reaches SH_CNT_N with invld_cnt=0, set lock_o (or hold it at 1) and clear both counters.
REQ-018 SHALL, when sh_cnt reaches SH_CNT_N with 0<invld_cnt<INVLD_MAX while locked, hold lock_o at 1 and clear both counters.
REQ-019 SHALL give the slip rule (REQ-015/016) priority over the window-end rule when both apply to the same header.
REQ-020 SHALL register all outputs: slip_o and a lock_o change appear on the cycle after the deciding header.
REQ-021 SHALL keep slip_o at 1 for exactly one cycle per slip, and never on consecutive cycles.
REQ-022 SHALL stay in SLIP_WAIT for SLIP_WAIT_N cycles, counted from the cycle slip_o is high, ignoring valid_i and head_i.
REQ-023 SHALL return to TEST with both counters zero when SLIP_WAIT ends.
REQ-024 SHALL keep lock_o=0 throughout SLIP_WAIT.
REQ-025 SHALL NOT let the counters wrap; they are cleared exactly at their terminal values.

Reset
REQ-026 SHALL, on a cycle with rst=1, next-cycle drive lock_o=0 and slip_o=0, clear sh_cnt, invld_cnt and the wait counter, and enter TEST.
REQ-027 SHALL apply reset with priority over every event, including reset asserted mid-SLIP_WAIT or on the cycle a slip or lock decision occurs.
REQ-028 SHALL honour valid_i on the first cycle after rst deasserts.

Verification
REQ-029 SHALL verify: reset, then 64 consecutive valid_i with head_i=2'b01 -> lock_o=1 on the cycle after the 64th, and slip_o never high.
REQ-030 SHALL verify: unlocked, 9 valid headers, then head_i=2'b11 -> slip_o=1 for one cycle; the next 3 cycles are ignored even with valid_i=1; lock follows after 64 further valid headers.
REQ-031 SHALL verify: locked, a window with 15 invalid and 49 valid headers -> lock_o stays 1 with no slip; next window, the 16th invalid header -> lock_o=0 and slip_o=1 on the same cycle.
REQ-032 SHALL verify: valid_i low 1 cycle in every 33, with all headers valid -> lock after exactly 64 accepted headers, since gap cycles are not counted.
REQ-033 SHALL verify: rst=1 during the 2nd SLIP_WAIT cycle -> outputs 0 next cycle; then 64 valid headers -> lock_o=1.
REQ-034 SHALL verify: locked, a window with 1 invalid header -> lock_o stays 1; the next clean window keeps lock_o=1.
